// File: rtl/uart_frame_ctrl.sv
// rtl/uart_frame_ctrl.sv - UART transmitter (multi-frame commands) and receiver
// TX and RX share only the bit-period divisor; each runs its own FSM and counters.
module uart_frame_ctrl #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 2,
  parameter int STOP_BITS = 1,
  parameter int CMD_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CMD_WIDTH-1:0] cmd_in,
  input  logic                 cmd_vld,
  output logic                 cmd_rdy,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] read_data,
  output logic                 read_rdy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 tx_busy
);

  localparam int DIV      = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int N_FRAMES = CMD_WIDTH / DATA_BITS;
  localparam int FW       = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'((DIV / 2 > 0) ? DIV / 2 - 1 : 0);
  localparam logic          ODD     = (PARITY == 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  tx_state_t            tx_state, tx_next;
  logic [CW-1:0]        tx_cnt;
  logic [3:0]           tx_bit;
  logic [FW-1:0]        tx_frame;
  logic [CMD_WIDTH-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_done;

  assign tx_done = (tx_cnt == DIV_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    tx      = 1'b1;
    cmd_rdy = 1'b0;
    tx_busy = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        cmd_rdy = 1'b1;
        tx_busy = 1'b0;
        if (cmd_vld) tx_next = TX_START;
      end
      TX_START: begin
        tx = 1'b0;
        if (tx_done) tx_next = TX_DATA;
      end
      TX_DATA: begin
        tx = tx_shift[0];
        if (tx_done && tx_bit == 4'(DATA_BITS - 1))
          tx_next = (PARITY != 0) ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin
        tx = tx_par ^ ODD;
        if (tx_done) tx_next = TX_STOP;
      end
      TX_STOP: begin
        if (tx_done && tx_bit == 4'(STOP_BITS - 1))
          tx_next = (tx_frame == FW'(N_FRAMES - 1)) ? TX_IDLE : TX_START;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  // The shift register walks the whole command, so the next word is already at the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_frame <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else if (tx_state == TX_IDLE) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_frame <= '0;
      tx_par   <= 1'b0;
      if (cmd_vld) tx_shift <= cmd_in;
    end else begin
      tx_cnt <= tx_done ? '0 : tx_cnt + 1'b1;
      if (tx_done) begin
        tx_bit <= (tx_next != tx_state) ? 4'd0 : tx_bit + 4'd1;
        if (tx_state == TX_START) tx_par <= 1'b0;
        if (tx_state == TX_DATA) begin
          tx_shift <= tx_shift >> 1;
          tx_par   <= tx_par ^ tx_shift[0];
        end
        if (tx_state == TX_STOP && tx_next == TX_START) tx_frame <= tx_frame + 1'b1;
      end
    end
  end

  rx_state_t            rx_state, rx_next;
  logic                 rx_s1, rx_s2, rx_prev;
  logic [CW-1:0]        rx_cnt;
  logic [3:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par, rx_perr;
  logic                 rx_tick;

  // Start bit is sampled after half a period, every later bit a full period on.
  assign rx_tick = (rx_state == RX_START) ? (rx_cnt == HALF_M1) : (rx_cnt == DIV_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:      if (rx_prev && !rx_s2) rx_next = RX_START;
      RX_START:     if (rx_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:      if (rx_tick && rx_bit == 4'(DATA_BITS - 1))
                      rx_next = (PARITY != 0) ? RX_PARITY : RX_STOP;
      RX_PARITY:    if (rx_tick) rx_next = RX_STOP;
      RX_STOP:      if (rx_tick) rx_next = rx_s2 ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rx_s2) rx_next = RX_IDLE;
      default:      rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_par     <= 1'b0;
      rx_perr    <= 1'b0;
      read_data  <= '0;
      read_rdy   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      read_rdy   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (rx_state == RX_IDLE || rx_state == RX_WAIT_HIGH || rx_tick) rx_cnt <= '0;
      else                                                           rx_cnt <= rx_cnt + 1'b1;
      if (rx_tick) begin
        case (rx_state)
          RX_START: begin
            rx_bit  <= '0;
            rx_par  <= 1'b0;
            rx_perr <= 1'b0;
          end
          RX_DATA: begin
            rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
            rx_par   <= rx_par ^ rx_s2;
            rx_bit   <= rx_bit + 4'd1;
          end
          RX_PARITY: rx_perr <= ((rx_par ^ rx_s2) != ODD);
          RX_STOP: begin
            if (rx_s2) begin
              read_data  <= rx_shift;
              read_rdy   <= 1'b1;
              parity_err <= rx_perr;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb/tb_uart_frame_ctrl.sv - directed self-checking bench for uart_frame_ctrl
module tb_uart_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cmd_in;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic        tx;
  logic        rx;
  logic [7:0]  read_data;
  logic        read_rdy;
  logic        parity_err;
  logic        frame_err;
  logic        tx_busy;

  int n_cmp = 0;
  int n_bad = 0;

  int rdy_cnt = 0, pe_cnt = 0, fe_cnt = 0, pe_with_rdy = 0;
  logic [7:0] last_data = 8'h00;

  uart_frame_ctrl #(
    .CLK_FREQ (1_152_000),
    .BAUD     (115200),
    .DATA_BITS(8),
    .PARITY   (2),
    .STOP_BITS(1),
    .CMD_WIDTH(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_in    (cmd_in),
    .cmd_vld   (cmd_vld),
    .cmd_rdy   (cmd_rdy),
    .tx        (tx),
    .rx        (rx),
    .read_data (read_data),
    .read_rdy  (read_rdy),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .tx_busy   (tx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (read_rdy) begin
      rdy_cnt   <= rdy_cnt + 1;
      last_data <= read_data;
      if (parity_err) pe_with_rdy <= pe_with_rdy + 1;
    end
    if (parity_err) pe_cnt <= pe_cnt + 1;
    if (frame_err)  fe_cnt <= fe_cnt + 1;
  end

  task automatic test_reset();
    rst_n = 1'b0; cmd_vld = 1'b0; cmd_in = 16'h0000; rx = 1'b1;
    #12;
    n_cmp++; if (tx !== 1'b1)         begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_cmp++; if (cmd_rdy !== 1'b1)    begin n_bad++; $display("FAIL reset_cmd_rdy: got %b want 1", cmd_rdy); end
    n_cmp++; if (tx_busy !== 1'b0)    begin n_bad++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
    n_cmp++; if ({read_rdy, parity_err, frame_err} !== 3'b000)
      begin n_bad++; $display("FAIL reset_pulses: got %b want 000", {read_rdy, parity_err, frame_err}); end
    n_cmp++; if (read_data !== 8'h00) begin n_bad++; $display("FAIL reset_read_data: got %h want 00", read_data); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_tx(input logic [15:0] cmd, input bit poke);
    int bad = 0, busy_bad = 0, idle_bad = 0;
    int f, b;
    logic [7:0] d;
    logic exp;
    @(negedge clk);
    n_cmp++; if (cmd_rdy !== 1'b1) begin n_bad++; $display("FAIL tx_pre_rdy: got %b want 1", cmd_rdy); end
    cmd_in = cmd; cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0; cmd_in = 16'hFFFF;
    n_cmp++; if (cmd_rdy !== 1'b0) begin n_bad++; $display("FAIL tx_rdy_fall: got %b want 0", cmd_rdy); end
    for (int n = 0; n < 220; n++) begin
      f = n / 110;
      b = (n % 110) / 10;
      d = cmd[f*8 +: 8];
      if (b == 0)       exp = 1'b0;
      else if (b <= 8)  exp = d[b-1];
      else if (b == 9)  exp = ^d;
      else              exp = 1'b1;
      if (tx !== exp) bad++;
      if (tx_busy !== 1'b1) busy_bad++;
      if (poke && n == 50) begin cmd_vld = 1'b1; cmd_in = 16'h0F0F; end
      if (poke && n == 51) cmd_vld = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (bad != 0)      begin n_bad++; $display("FAIL tx_bits_%h: %0d wrong cycles, want 0", cmd, bad); end
    n_cmp++; if (busy_bad != 0) begin n_bad++; $display("FAIL tx_busy_%h: %0d low cycles, want 0", cmd, busy_bad); end
    n_cmp++; if (cmd_rdy !== 1'b1 || tx_busy !== 1'b0 || tx !== 1'b1)
      begin n_bad++; $display("FAIL tx_end_%h: rdy/busy/tx=%b%b%b want 101", cmd, cmd_rdy, tx_busy, tx); end
    if (poke) begin
      for (int n = 0; n < 30; n++) begin
        if (tx !== 1'b1 || tx_busy !== 1'b0) idle_bad++;
        @(negedge clk);
      end
      n_cmp++; if (idle_bad != 0) begin n_bad++; $display("FAIL tx_ignored_cmd: %0d active cycles, want 0", idle_bad); end
    end
  endtask

  task automatic rx_send(input logic [7:0] d, input logic par, input logic stop);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx = bits[i];
      repeat (10) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic test_rx_good(input logic [7:0] d);
    int r0 = rdy_cnt, p0 = pe_cnt, f0 = fe_cnt;
    rx_send(d, ^d, 1'b1);
    repeat (20) @(negedge clk);
    n_cmp++; if (rdy_cnt - r0 != 1) begin n_bad++; $display("FAIL rx_good_rdy_%h: got %0d pulses want 1", d, rdy_cnt - r0); end
    n_cmp++; if (last_data !== d)   begin n_bad++; $display("FAIL rx_good_data: got %h want %h", last_data, d); end
    n_cmp++; if (pe_cnt != p0 || fe_cnt != f0)
      begin n_bad++; $display("FAIL rx_good_err_%h: pe %0d fe %0d want 0 0", d, pe_cnt - p0, fe_cnt - f0); end
  endtask

  task automatic test_rx_parity();
    int r0 = rdy_cnt, p0 = pe_cnt, pr0 = pe_with_rdy;
    rx_send(8'h5A, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    n_cmp++; if (rdy_cnt - r0 != 1)          begin n_bad++; $display("FAIL rx_par_rdy: got %0d want 1", rdy_cnt - r0); end
    n_cmp++; if (pe_with_rdy - pr0 != 1 || pe_cnt - p0 != 1)
      begin n_bad++; $display("FAIL rx_par_err: with_rdy %0d total %0d want 1 1", pe_with_rdy - pr0, pe_cnt - p0); end
    n_cmp++; if (last_data !== 8'h5A)        begin n_bad++; $display("FAIL rx_par_data: got %h want 5a", last_data); end
  endtask

  task automatic test_rx_frame();
    int r0 = rdy_cnt, f0 = fe_cnt;
    rx_send(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++; if (fe_cnt - f0 != 1)     begin n_bad++; $display("FAIL rx_frm_err: got %0d want 1", fe_cnt - f0); end
    n_cmp++; if (rdy_cnt != r0)        begin n_bad++; $display("FAIL rx_frm_rdy: got %0d want 0", rdy_cnt - r0); end
    n_cmp++; if (read_data !== 8'h5A)  begin n_bad++; $display("FAIL rx_frm_hold: got %h want 5a", read_data); end
    test_rx_good(8'h81);
  endtask

  task automatic test_rx_glitch();
    int r0 = rdy_cnt, p0 = pe_cnt, f0 = fe_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    n_cmp++; if (rdy_cnt != r0 || pe_cnt != p0 || fe_cnt != f0)
      begin n_bad++; $display("FAIL rx_glitch: rdy %0d pe %0d fe %0d want 0 0 0", rdy_cnt - r0, pe_cnt - p0, fe_cnt - f0); end
  endtask

  task automatic test_concurrent();
    fork
      test_tx(16'h1234, 1'b0);
      test_rx_good(8'hC3);
    join
  endtask

  task automatic test_reset_mid_tx();
    int bad = 0;
    @(negedge clk);
    cmd_in = 16'hAAAA; cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (tx !== 1'b1 || cmd_rdy !== 1'b1 || tx_busy !== 1'b0)
      begin n_bad++; $display("FAIL rst_mid_tx: tx/rdy/busy=%b%b%b want 110", tx, cmd_rdy, tx_busy); end
    @(negedge clk); rst_n = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
      @(negedge clk);
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL rst_no_resume: %0d active cycles want 0", bad); end
    test_tx(16'h00FF, 1'b0);
  endtask

  initial begin
    test_reset();
    test_tx(16'hAAAA, 1'b1);
    test_tx(16'h1234, 1'b0);
    test_rx_good(8'h5A);
    test_rx_parity();
    test_rx_frame();
    test_rx_glitch();
    test_concurrent();
    test_reset_mid_tx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
